fifo_wr_ctrl: RTL and testbench

- Write-side controller of the dual-clock FIFO, running entirely in the wr_clk domain.
- Keeps the binary and Gray write pointers and drives the write-port address/enable of the dual-port RAM.
- Takes the read pointer already synchronized into wr_clk, and from it derives full, almost-full, occupancy level and a sticky overflow flag.
- Its Gray write pointer is the signal the opposite-direction synchronizer carries into the read domain.

---
 rtl/fifo_wr_ctrl.sv | 72 +++++++
 tb/tb_fifo_wr_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-side pointer, full/level and overflow control of the dual-clock FIFO
module fifo_wr_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int AF_THRESH = 2
) (
    input  logic              wr_clk,
    input  logic              wr_rst,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   wq2_rd_ptr,
    input  logic              ovf_clr,
    output logic [ADDR_W:0]   wr_ptr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_mem_en,
    output logic              wr_full,
    output logic              wr_almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              wr_overflow
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] AF_V    = (ADDR_W+1)'(AF_THRESH);

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] rbin_s;
    logic [ADDR_W:0] full_cmp;
    logic [ADDR_W:0] level_next;
    logic [ADDR_W:0] free_next;

    // A write is only ever accepted while not full; this gates both the RAM and the pointer.
    assign wr_mem_en = wr_en & ~wr_full;
    assign wr_addr   = wbin[ADDR_W-1:0];

    // Next pointers, synchronized read pointer decode and the flag terms derived from them.
    always_comb begin
        wbin_next  = wbin + {{ADDR_W{1'b0}}, wr_mem_en};
        wgray_next = wbin_next ^ (wbin_next >> 1);
        rbin_s     = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rbin_s[i] = ^(wq2_rd_ptr >> i);
        end
        // Full in Gray space: the two top bits differ from the read pointer, the rest match.
        full_cmp   = {~wq2_rd_ptr[ADDR_W:ADDR_W-1], wq2_rd_ptr[ADDR_W-2:0]};
        level_next = wbin_next - rbin_s;
        free_next  = DEPTH_V - level_next;
    end

    // Pointer, flag and occupancy registers; flags look ahead to wbin_next so full asserts with no lag.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wbin           <= '0;
            wr_ptr         <= '0;
            wr_full        <= 1'b0;
            wr_almost_full <= 1'b0;
            wr_level       <= '0;
            wr_overflow    <= 1'b0;
        end else begin
            wbin           <= wbin_next;
            wr_ptr         <= wgray_next;
            wr_full        <= (wgray_next == full_cmp);
            wr_almost_full <= (free_next <= AF_V);
            wr_level       <= level_next;
            if (wr_en & wr_full) begin
                wr_overflow <= 1'b1;
            end else if (ovf_clr) begin
                wr_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - scoreboard bench for fifo_wr_ctrl
module tb_fifo_wr_ctrl;

    localparam int ADDR_W    = 3;
    localparam int AF_THRESH = 2;
    localparam int DEPTH     = 8;

    logic              wr_clk = 1'b0;
    logic              wr_rst;
    logic              wr_en;
    logic [ADDR_W:0]   wq2_rd_ptr;
    logic              ovf_clr;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_mem_en;
    logic              wr_full;
    logic              wr_almost_full;
    logic [ADDR_W:0]   wr_level;
    logic              wr_overflow;

    fifo_wr_ctrl #(.ADDR_W(ADDR_W), .AF_THRESH(AF_THRESH)) dut (
        .wr_clk        (wr_clk),
        .wr_rst        (wr_rst),
        .wr_en         (wr_en),
        .wq2_rd_ptr    (wq2_rd_ptr),
        .ovf_clr       (ovf_clr),
        .wr_ptr        (wr_ptr),
        .wr_addr       (wr_addr),
        .wr_mem_en     (wr_mem_en),
        .wr_full       (wr_full),
        .wr_almost_full(wr_almost_full),
        .wr_level      (wr_level),
        .wr_overflow   (wr_overflow)
    );

    always #5 wr_clk = ~wr_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] ptr;
        logic       full;
        logic       af;
        logic [3:0] level;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    int m_w;
    int m_r;
    bit m_full;
    bit m_ovf;
    logic [3:0] prev_ptr;

    function automatic logic [3:0] gray(input int v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    // One wr_clk cycle: drive inputs, predict, push, clock, pop and compare.
    task automatic cycle(input bit en, input bit clr, input int rcnt);
        exp_t e;
        exp_t got;
        int   lvl;
        wr_en      = en;
        ovf_clr    = clr;
        m_r        = rcnt;
        wq2_rd_ptr = gray(rcnt);
        #1;
        check("mem_en", 32'(wr_mem_en), 32'(en & !m_full));
        check("addr", 32'(wr_addr), 32'(m_w % DEPTH));
        if (en && m_full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (en && !m_full) m_w = (m_w + 1) % 16;
        lvl     = (m_w - m_r) & 15;
        m_full  = (lvl == DEPTH);
        e.ptr   = gray(m_w);
        e.full  = m_full;
        e.af    = ((DEPTH - lvl) <= AF_THRESH);
        e.level = 4'(lvl);
        e.ovf   = m_ovf;
        sb.push_back(e);
        @(posedge wr_clk);
        #1;
        got = sb.pop_front();
        check("wr_ptr", 32'(wr_ptr), 32'(got.ptr));
        check("wr_full", 32'(wr_full), 32'(got.full));
        check("wr_almost_full", 32'(wr_almost_full), 32'(got.af));
        check("wr_level", 32'(wr_level), 32'(got.level));
        check("wr_overflow", 32'(wr_overflow), 32'(got.ovf));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ptr"}, 32'(wr_ptr), 32'h0);
        check({tag, "_addr"}, 32'(wr_addr), 32'h0);
        check({tag, "_full"}, 32'(wr_full), 32'h0);
        check({tag, "_af"}, 32'(wr_almost_full), 32'h0);
        check({tag, "_level"}, 32'(wr_level), 32'h0);
        check({tag, "_ovf"}, 32'(wr_overflow), 32'h0);
    endtask

    initial begin
        wr_rst     = 1'b1;
        wr_en      = 1'b0;
        ovf_clr    = 1'b0;
        wq2_rd_ptr = '0;
        m_w = 0; m_r = 0; m_full = 0; m_ovf = 0;
        repeat (2) @(posedge wr_clk);
        #1;
        check_all_zero("reset");
        wr_rst = 1'b0;

        // Fill from empty: Gray sequence, almost-full from level 6, full on the 8th write.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 0);
        check("fill_ptr_C", 32'(wr_ptr), 32'hC);

        // Writes while full are dropped and set overflow; clear drops it.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0);
        check("full_hold_ptr", 32'(wr_ptr), 32'hC);
        cycle(1'b0, 1'b1, 0);

        // One read frees a slot; the next write refills it.
        cycle(1'b0, 1'b0, 1);
        cycle(1'b1, 1'b0, 1);
        check("refill_ptr_D", 32'(wr_ptr), 32'hD);

        // Drain to level 2, then write with the read pointer trailing: wrap with single-bit steps.
        for (int i = 2; i <= 7; i++) cycle(1'b0, 1'b0, i);
        prev_ptr = wr_ptr;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, m_w - 1);
            check("gray_step", 32'($countones(prev_ptr ^ wr_ptr)), 32'd1);
            prev_ptr = wr_ptr;
        end

        // Build to level 7, then write and read in the same cycle.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, m_r);
        cycle(1'b1, 1'b0, m_r + 1);
        check("simul_level", 32'(wr_level), 32'd7);

        // Down to level 5, then reset in the middle of a write burst.
        cycle(1'b0, 1'b0, m_r + 1);
        cycle(1'b0, 1'b0, m_r + 1);
        cycle(1'b1, 1'b0, m_r);
        wr_en = 1'b1;
        #2;
        wr_rst     = 1'b1;
        wq2_rd_ptr = '0;
        #1;
        check_all_zero("async_rst");
        @(posedge wr_clk);
        #1;
        wr_rst = 1'b0;
        m_w = 0; m_r = 0; m_full = 0; m_ovf = 0;
        cycle(1'b1, 1'b0, 0);
        check("post_rst_ptr", 32'(wr_ptr), 32'h1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
